rle_stream_decoder: RTL and testbench
=====================================

RLE_STREAM_DECODER -- requirements
Module: rle_stream_decoder

Interface
REQ-001 SHALL have parameter RUN_W, default 6, meaning the zero-run field width.
REQ-002 SHALL have parameter LVL_W, default 8, meaning the signed coefficient level width.
REQ-003 SHALL have parameter BLK_N, default 64, meaning coefficients per block in zigzag order.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sym_valid  input  1  symbol present on sym_data.
REQ-007 SHALL have port sym_data  input  RUN_W+LVL_W (14)  symbol {run[13:8], level[7:0]}, with EOB = 14'h0000.
REQ-008 SHALL have port sym_ready  output  1  decoder accepts sym_data this cycle.
REQ-009 SHALL have port coef_valid  output  1  registered coefficient valid.
REQ-010 SHALL have port coef_ready  input  1  downstream (inverse zigzag) accepts coefficient.
REQ-011 SHALL have port coef_data  output  LVL_W  signed coefficient.
REQ-012 SHALL have port coef_index  output  6  zigzag position 0..63 of coef_data.
REQ-013 SHALL have port block_done  output  1  high with the coefficient at index 63.
REQ-014 SHALL have port err_overrun  output  1  one-cycle pulse when a symbol's run overflows the block.

Function
REQ-015 SHALL implement the states FETCH, RUN, LEVEL and FILL.
REQ-016 SHALL assert sym_ready only in FETCH while the output register is empty or being drained (coef_valid=0 or coef_ready=1).
REQ-017 SHALL, on accepting a non-EOB symbol, latch run and level and go to RUN if run>0, else to LEVEL.
REQ-018 SHALL, on accepting EOB, go to FILL.
REQ-019 SHALL, in RUN, emit one zero per handshake, decrementing run, and go to LEVEL after the last zero.
REQ-020 SHALL, in LEVEL, emit the latched level once and return to FETCH.
REQ-021 SHALL, in FILL, emit zeros until index 63 is emitted and then return to FETCH.
REQ-022 SHALL, on EOB received at index 0, produce 64 zeros as the all-zero block.
REQ-023 SHALL advance the output (coef_valid/coef_data/coef_index) only when coef_valid=0 or coef_ready=1, and hold it stable while coef_valid=1 and coef_ready=0.
REQ-024 SHALL give a one-cycle latency from symbol acceptance to the first resulting coef_valid, and then sustain one coefficient per cycle under continuous coef_ready.
REQ-025 SHALL increment coef_index per emitted coefficient and wrap 63->0, with block_done=1 exactly on index 63.
REQ-026 SHALL end the block after a level lands at index 63 without an EOB; the next symbol belongs to the next block.
REQ-027 SHALL, when run+1 exceeds the remaining positions, emit zeros through index 63, drop the level, pulse err_overrun on the cycle the symbol is accepted, and return to FETCH.
REQ-028 SHALL pass the level bits unmodified (two's complement, no saturation).

Reset
REQ-029 SHALL, on reset assertion at any time including mid-block, immediately drive state=FETCH, index=0, run=0, coef_valid=0, coef_data=0, coef_index=0, block_done=0, err_overrun=0 and sym_ready=0.
REQ-030 SHALL drive sym_ready=1 on the first cycle after deassertion; partial blocks are discarded.

Structure
REQ-031 SHALL take the state enum, RUN_W/LVL_W/BLK_N defaults and the EOB constant from shared package jpeg_codec_pkg, which the encoder side also uses.
REQ-032 SHALL be a single module with no sub-module; the output register and index counter are inline.

Verification
REQ-033 SHALL cover: symbols (0,+50),(2,-3),EOB -> coefficients 50,0,0,-3 then 60 zeros, block_done on index 63.
REQ-034 SHALL cover: single EOB -> 64 zeros, indices 0..63, one block_done.
REQ-035 SHALL cover: (63,+7) with no EOB -> 63 zeros then 7 at index 63; the next symbol (0,1) -> 1 at index 0 of the next block.
REQ-036 SHALL cover: (10,5) accepted at index 60 -> zeros at 60..63, err_overrun one pulse, level 5 never emitted.
REQ-037 SHALL cover: coef_ready held low for 3 cycles mid-run -> coef_data/coef_index stable, sym_ready=0, and no coefficient lost or duplicated.
REQ-038 SHALL cover: reset asserted at index 20 -> outputs zero in the same cycle; a subsequent EOB yields a clean 64-zero block starting at index 0.

Source files
------------

// File: rtl/jpeg_codec_pkg.sv
// Shared JPEG codec definitions used by both the encoder and decoder sides.
//   DEF_RUN_W / DEF_LVL_W / DEF_BLK_N : default zero-run width, level width,
//                                       coefficients per block
//   EOB_SYM                           : end-of-block symbol (run=0, level=0)
//   rle_state_e                       : run-length decoder FSM states
package jpeg_codec_pkg;

    localparam int unsigned DEF_RUN_W = 6;
    localparam int unsigned DEF_LVL_W = 8;
    localparam int unsigned DEF_BLK_N = 64;

    localparam logic [DEF_RUN_W+DEF_LVL_W-1:0] EOB_SYM = '0;

    typedef enum logic [1:0] {
        StFetch,
        StRun,
        StLevel,
        StFill
    } rle_state_e;

endpackage

// File: rtl/rle_stream_decoder.sv
// Run-length symbol decoder: expands {run, level} symbols into a zigzag-ordered
// coefficient stream, one block of BLK_N coefficients at a time.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   sym_valid/sym_ready : symbol handshake, sym_data = {run, level}, EOB = all zero
//   coef_valid/ready    : registered coefficient output handshake
//   coef_data           : signed level or zero
//   coef_index          : zigzag position of coef_data
//   block_done          : high with the last coefficient of a block
//   err_overrun         : pulses on the accept cycle of a symbol that overflows the block
module rle_stream_decoder
    import jpeg_codec_pkg::*;
#(
    parameter int unsigned RUN_W = DEF_RUN_W,
    parameter int unsigned LVL_W = DEF_LVL_W,
    parameter int unsigned BLK_N = DEF_BLK_N
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sym_valid,
    input  logic [RUN_W+LVL_W-1:0]     sym_data,
    output logic                       sym_ready,
    output logic                       coef_valid,
    input  logic                       coef_ready,
    output logic [LVL_W-1:0]           coef_data,
    output logic [$clog2(BLK_N)-1:0]   coef_index,
    output logic                       block_done,
    output logic                       err_overrun
);

    localparam int unsigned IDX_W = $clog2(BLK_N);
    localparam int unsigned SYM_W = RUN_W + LVL_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_N - 1);

    rle_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;        // next zigzag position to emit
    logic [RUN_W-1:0]  run_q, run_d;        // zeros still owed before the level
    logic [LVL_W-1:0]  level_q, level_d;

    logic              coef_valid_q, coef_valid_d;
    logic [LVL_W-1:0]  coef_data_q, coef_data_d;
    logic [IDX_W-1:0]  coef_index_q, coef_index_d;
    logic              block_done_q, block_done_d;

    logic [RUN_W-1:0]  sym_run;
    logic [LVL_W-1:0]  sym_level;
    logic              is_eob;
    logic              advance;
    logic              accept;
    logic              overrun;
    logic              emit;
    logic [LVL_W-1:0]  emit_data;

    assign sym_run   = sym_data[SYM_W-1 -: RUN_W];
    assign sym_level = sym_data[LVL_W-1:0];
    assign is_eob    = (sym_data == SYM_W'(EOB_SYM));

    // Output register may take a new value when empty or being drained.
    assign advance   = !coef_valid_q || coef_ready;
    // Gated by reset so the handshake is closed while reset is held.
    assign sym_ready = !reset && (state_q == StFetch) && advance;
    assign accept    = sym_valid && sym_ready;
    // run zeros plus the level must fit in the positions left in this block.
    assign overrun   = accept && !is_eob &&
                       ((32'(sym_run) + 32'd1) > (BLK_N - 32'(idx_q)));
    assign err_overrun = overrun;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        run_d        = run_q;
        level_d      = level_q;
        coef_valid_d = coef_valid_q;
        coef_data_d  = coef_data_q;
        coef_index_d = coef_index_q;
        block_done_d = block_done_q;
        emit         = 1'b0;
        emit_data    = '0;

        if (advance) begin
            coef_valid_d = 1'b0;
            block_done_d = 1'b0;
        end

        unique case (state_q)
            StFetch: begin
                if (accept) begin
                    if (is_eob || overrun) begin
                        // Overrun drops the level and zero-fills the block.
                        state_d = StFill;
                    end else begin
                        run_d   = sym_run;
                        level_d = sym_level;
                        state_d = (sym_run != '0) ? StRun : StLevel;
                    end
                end
            end
            StRun: begin
                if (advance) begin
                    emit  = 1'b1;
                    run_d = run_q - RUN_W'(1);
                    if (run_q == RUN_W'(1)) begin
                        state_d = StLevel;
                    end
                end
            end
            StLevel: begin
                if (advance) begin
                    emit      = 1'b1;
                    emit_data = level_q;
                    state_d   = StFetch;
                end
            end
            StFill: begin
                if (advance) begin
                    emit = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = StFetch;
                    end
                end
            end
        endcase

        if (emit) begin
            coef_valid_d = 1'b1;
            coef_data_d  = emit_data;
            coef_index_d = idx_q;
            block_done_d = (idx_q == LAST_IDX);
            idx_d        = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            idx_q        <= '0;
            run_q        <= '0;
            level_q      <= '0;
            coef_valid_q <= 1'b0;
            coef_data_q  <= '0;
            coef_index_q <= '0;
            block_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            run_q        <= run_d;
            level_q      <= level_d;
            coef_valid_q <= coef_valid_d;
            coef_data_q  <= coef_data_d;
            coef_index_q <= coef_index_d;
            block_done_q <= block_done_d;
        end
    end

    assign coef_valid = coef_valid_q;
    assign coef_data  = coef_data_q;
    assign coef_index = coef_index_q;
    assign block_done = block_done_q;

endmodule

// File: tb/tb_rle_stream_decoder.sv
module tb_rle_stream_decoder;

    logic        clk;
    logic        reset;
    logic        sym_valid;
    logic [13:0] sym_data;
    logic        sym_ready;
    logic        coef_valid;
    logic        coef_ready;
    logic [7:0]  coef_data;
    logic [5:0]  coef_index;
    logic        block_done;
    logic        err_overrun;

    rle_stream_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_ready   (sym_ready),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_data   (coef_data),
        .coef_index  (coef_index),
        .block_done  (block_done),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Expected {block_done, index, data} per coefficient, oldest first.
    logic [14:0] sb[$];
    int          exp_idx = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          ovr_seen = 0;
    bit          force_stall = 0;
    bit          rand_en = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void push_exp(input logic [7:0] d);
        sb.push_back({(exp_idx == 63), 6'(exp_idx), d});
        exp_idx = (exp_idx + 1) % 64;
    endfunction

    // Reference model of one symbol; returns the expected overrun flag.
    function automatic logic model_push(input int run, input int lvl);
        if (run == 0 && (lvl % 256) == 0) begin
            do push_exp(8'h00); while (exp_idx != 0);
            return 1'b0;
        end
        if (run + 1 > 64 - exp_idx) begin
            do push_exp(8'h00); while (exp_idx != 0);
            return 1'b1;
        end
        for (int i = 0; i < run; i++) push_exp(8'h00);
        push_exp(8'(lvl));
        return 1'b0;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        coef_ready = force_stall ? 1'b0 : (rand_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (err_overrun) ovr_seen++;
        if (coef_valid && coef_ready) begin
            if (block_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sb.size() == 0) begin
                check_eq("sb_depth", 32'(sb.size()), 32'd1);
            end else begin
                check_eq("coef", {17'd0, block_done, coef_index, coef_data}, {17'd0, sb.pop_front()});
            end
        end
    end

    task automatic send_sym(input int run, input int lvl);
        bit   ok = 0;
        logic exp_ovr;
        @(posedge clk);
        #1;
        sym_data  = {6'(run), 8'(lvl)};
        sym_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (sym_ready) begin
                exp_ovr = model_push(run, lvl);
                check_eq("err_overrun", 32'(err_overrun), 32'(exp_ovr));
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        acc_cyc   = cyc;
        sym_valid = 1'b0;
        sym_data  = '0;
        check_eq("sym_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    int          d0;
    int          o0;
    logic [7:0]  cap_d;
    logic [5:0]  cap_i;
    bit          found;

    initial begin
        reset      = 1'b1;
        sym_valid  = 1'b0;
        sym_data   = '0;
        coef_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_coef_valid", 32'(coef_valid), 32'd0);
        check_eq("rst_coef_data", 32'(coef_data), 32'd0);
        check_eq("rst_coef_index", 32'(coef_index), 32'd0);
        check_eq("rst_block_done", 32'(block_done), 32'd0);
        check_eq("rst_err_overrun", 32'(err_overrun), 32'd0);
        check_eq("rst_sym_ready", 32'(sym_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_sym_ready", 32'(sym_ready), 32'd1);

        // 50, 0, 0, -3, then 60 zeros.
        d0 = done_cnt;
        send_sym(0, 50);
        @(negedge clk);
        @(negedge clk);
        check_eq("latency_valid", 32'(coef_valid), 32'd1);
        send_sym(2, -3);
        send_sym(0, 0);
        wait_drain();
        check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Lone EOB: 64 zeros at one per cycle.
        d0 = done_cnt;
        send_sym(0, 0);
        wait_drain();
        check_eq("eob_cycles", 32'(done_cyc - acc_cyc), 32'd64);
        check_eq("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Level lands at 63 without EOB; next symbol starts the next block.
        send_sym(63, 7);
        send_sym(0, 1);
        send_sym(0, 0);
        wait_drain();

        // Overrun at index 60.
        send_sym(59, 1);
        o0 = ovr_seen;
        send_sym(10, 5);
        wait_drain();
        check_eq("ovr_pulses", 32'(ovr_seen - o0), 32'd1);

        // Downstream stall for three cycles mid-run.
        send_sym(20, 3);
        repeat (5) @(negedge clk);
        force_stall = 1;
        @(posedge clk);
        #2;
        cap_d = coef_data;
        cap_i = coef_index;
        repeat (3) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(coef_valid), 32'd1);
            check_eq("stall_data", 32'(coef_data), 32'(cap_d));
            check_eq("stall_index", 32'(coef_index), 32'(cap_i));
            check_eq("stall_sym_ready", 32'(sym_ready), 32'd0);
        end
        force_stall = 0;
        send_sym(0, 0);
        wait_drain();

        // Random symbols with random downstream back-pressure.
        rand_en = 1;
        for (int n = 0; n < 12; n++) begin
            send_sym(int'($urandom_range(0, 20)), int'($urandom_range(0, 255)));
        end
        if (exp_idx != 0) send_sym(0, 0);
        wait_drain();
        rand_en = 0;

        // Reset mid-block at index 20.
        send_sym(63, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (coef_valid && coef_index == 6'd20) found = 1;
        end
        check_eq("rst_reach20", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_coef_valid", 32'(coef_valid), 32'd0);
        check_eq("mid_rst_coef_data", 32'(coef_data), 32'd0);
        check_eq("mid_rst_coef_index", 32'(coef_index), 32'd0);
        check_eq("mid_rst_sym_ready", 32'(sym_ready), 32'd0);
        sb.delete();
        exp_idx = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_release_ready", 32'(sym_ready), 32'd1);
        d0 = done_cnt;
        send_sym(0, 0);
        wait_drain();
        check_eq("t7_done_cnt", 32'(done_cnt - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
